// File: rtl/mem_if_pkg.sv
// Shared constants and encodings for the main-memory arbiter.
// Client ids double as bit positions in request/grant vectors.
package mem_if_pkg;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    GAP    = 2'd3
  } arb_state_e;

  localparam logic CLIENT_I = 1'b0;
  localparam logic CLIENT_D = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins outright,
// on contention the client that did not win last time wins.
module rr_pick2
  import mem_if_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // one-hot grant indexed by client id
  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == CLIENT_D) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises icache and dcache block requests onto one memory
// port and routes the completion back to the owning client.
module mem_arbiter
  import mem_if_pkg::arb_state_e;
  import mem_if_pkg::IDLE;
  import mem_if_pkg::I_BUSY;
  import mem_if_pkg::D_BUSY;
  import mem_if_pkg::GAP;
  import mem_if_pkg::CLIENT_I;
  import mem_if_pkg::CLIENT_D;
#(
  parameter int ADDR_W        = 28,
  parameter int DATA_W        = 128,
  parameter bit FIRST_GRANT_D = 1'b1
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic              i_mem_ready,
  output logic [DATA_W-1:0] i_mem_rdata,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic              d_mem_ready,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              d_req;
  logic [1:0]        req;
  logic [1:0]        grant;

  assign d_req = d_mem_read | d_mem_write;
  assign req   = {d_req, i_mem_read};

  rr_pick2 u_pick (
    .req   (req),
    .last  (last_q),
    .grant (grant)
  );

  // next state, grant capture and completion release
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          grant[CLIENT_I]: begin
            state_d     = I_BUSY;
            mem_read_d  = 1'b1;
            mem_write_d = 1'b0;
            mem_addr_d  = i_mem_addr;
          end
          grant[CLIENT_D]: begin
            state_d     = D_BUSY;
            mem_read_d  = ~d_mem_write;
            mem_write_d = d_mem_write;
            mem_addr_d  = d_mem_addr;
            mem_wdata_d = d_mem_wdata;
          end
          default: ;
        endcase
        if (&req) begin
          last_d = grant[CLIENT_D] ? CLIENT_D : CLIENT_I;
        end
      end
      I_BUSY, D_BUSY: begin
        if (mem_ready) begin
          state_d     = GAP;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and memory-port registers
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q     <= IDLE;
      last_q      <= ~FIRST_GRANT_D;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  assign i_mem_ready = mem_ready & (state_q == I_BUSY);
  assign d_mem_ready = mem_ready & (state_q == D_BUSY);
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, corner sequences and a
// randomized run against a transaction-level model.
module tb_mem_arbiter;

  logic         clk;
  logic         proc_reset;
  logic         i_mem_read;
  logic [27:0]  i_mem_addr;
  logic         i_mem_ready;
  logic [127:0] i_mem_rdata;
  logic         d_mem_read;
  logic         d_mem_write;
  logic [27:0]  d_mem_addr;
  logic [127:0] d_mem_wdata;
  logic         d_mem_ready;
  logic [127:0] d_mem_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ready;
  logic [127:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(
    .ADDR_W        (28),
    .DATA_W        (128),
    .FIRST_GRANT_D (1'b1)
  ) dut (
    .clk         (clk),
    .proc_reset  (proc_reset),
    .i_mem_read  (i_mem_read),
    .i_mem_addr  (i_mem_addr),
    .i_mem_ready (i_mem_ready),
    .i_mem_rdata (i_mem_rdata),
    .d_mem_read  (d_mem_read),
    .d_mem_write (d_mem_write),
    .d_mem_addr  (d_mem_addr),
    .d_mem_wdata (d_mem_wdata),
    .d_mem_ready (d_mem_ready),
    .d_mem_rdata (d_mem_rdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic         ir;
    logic [27:0]  ia;
    logic         dr;
    logic         dw;
    logic [27:0]  da;
    logic [127:0] dwd;
    int           lat;
    logic [127:0] rd;
    logic         er;
    logic         ew;
    logic [27:0]  ea;
    logic [127:0] ewd;
    logic         eo;
  } vec_t;

  vec_t vt[8];

  task automatic chk1(input string nm, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", nm, a, e);
    end
  endtask

  task automatic chka(input string nm, input logic [27:0] a,
                      input logic [27:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic chkd(input string nm, input logic [127:0] a,
                      input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    i_mem_read  = 1'b0;
    i_mem_addr  = '0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    d_mem_addr  = '0;
    d_mem_wdata = '0;
    mem_ready   = 1'b0;
    mem_rdata   = '0;
  endtask

  task automatic do_reset();
    clr_in();
    proc_reset = 1'b1;
    #1;
    chk1("rst_rd", mem_read, 1'b0);
    chk1("rst_wr", mem_write, 1'b0);
    chka("rst_addr", mem_addr, 28'h0);
    chkd("rst_wdata", mem_wdata, 128'h0);
    tick();
    tick();
    proc_reset = 1'b0;
    tick();
  endtask

  // called in an IDLE cycle; runs one full transaction
  task automatic txn(input vec_t v);
    i_mem_read  = v.ir;
    i_mem_addr  = v.ia;
    d_mem_read  = v.dr;
    d_mem_write = v.dw;
    d_mem_addr  = v.da;
    d_mem_wdata = v.dwd;
    tick();
    chk1("v_rd", mem_read, v.er);
    chk1("v_wr", mem_write, v.ew);
    chka("v_addr", mem_addr, v.ea);
    if (v.ew) chkd("v_wdata", mem_wdata, v.ewd);
    for (int k = 1; k < v.lat; k++) begin
      tick();
      chka("v_hold", mem_addr, v.ea);
      chk1("v_noready", i_mem_ready | d_mem_ready, 1'b0);
    end
    mem_ready = 1'b1;
    mem_rdata = v.rd;
    #1;
    chk1("v_iready", i_mem_ready, v.eo == 1'b0);
    chk1("v_dready", d_mem_ready, v.eo == 1'b1);
    chkd("v_rdata", v.eo ? d_mem_rdata : i_mem_rdata, v.rd);
    tick();
    mem_ready = 1'b0;
    if (v.eo) begin
      d_mem_read  = 1'b0;
      d_mem_write = 1'b0;
    end else begin
      i_mem_read = 1'b0;
    end
    chk1("v_gap_rd", mem_read, 1'b0);
    chk1("v_gap_wr", mem_write, 1'b0);
    tick();
  endtask

  task automatic contention();
    logic exp_d;
    do_reset();
    i_mem_read  = 1'b1;
    i_mem_addr  = 28'h0000111;
    d_mem_write = 1'b1;
    d_mem_addr  = 28'h0000222;
    d_mem_wdata = 128'h5555;
    for (int k = 0; k < 6; k++) begin
      exp_d = (k % 2 == 0);
      tick();
      chk1("cont_wr", mem_write, exp_d);
      chk1("cont_rd", mem_read, ~exp_d);
      chka("cont_addr", mem_addr, exp_d ? 28'h0000222 : 28'h0000111);
      tick();
      mem_ready = 1'b1;
      mem_rdata = 128'(k);
      #1;
      chk1("cont_dready", d_mem_ready, exp_d);
      chk1("cont_iready", i_mem_ready, ~exp_d);
      tick();
      mem_ready = 1'b0;
      chk1("cont_gap", mem_read | mem_write, 1'b0);
      tick();
      chk1("cont_idle", mem_read | mem_write, 1'b0);
    end
    clr_in();
    tick();
    tick();
  endtask

  task automatic stability();
    do_reset();
    d_mem_read  = 1'b1;
    d_mem_write = 1'b1;
    d_mem_addr  = 28'h0000300;
    d_mem_wdata = 128'hCAFE;
    tick();
    chk1("rw_wr", mem_write, 1'b1);
    chk1("rw_rd", mem_read, 1'b0);
    d_mem_addr  = 28'h0000FFF;
    d_mem_wdata = 128'hDEAD;
    d_mem_read  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chka("rw_addr", mem_addr, 28'h0000300);
      chkd("rw_wdata", mem_wdata, 128'hCAFE);
      chk1("rw_wr_hold", mem_write, 1'b1);
    end
    mem_ready = 1'b1;
    #1;
    chk1("rw_dready", d_mem_ready, 1'b1);
    tick();
    clr_in();
    tick();
  endtask

  task automatic spurious();
    vec_t v;
    do_reset();
    mem_ready = 1'b1;
    mem_rdata = 128'h77;
    #1;
    chk1("sp_iready", i_mem_ready, 1'b0);
    chk1("sp_dready", d_mem_ready, 1'b0);
    tick();
    mem_ready = 1'b0;
    chk1("sp_strobe", mem_read | mem_write, 1'b0);
    v = '{1'b1, 28'h0000444, 1'b0, 1'b0, 28'h0, 128'h0, 2,
          128'h44, 1'b1, 1'b0, 28'h0000444, 128'h0, 1'b0};
    txn(v);
  endtask

  task automatic async_rst();
    vec_t v;
    do_reset();
    d_mem_write = 1'b1;
    d_mem_addr  = 28'h0000300;
    d_mem_wdata = 128'h99;
    tick();
    chk1("ar_wr_on", mem_write, 1'b1);
    #2;
    proc_reset = 1'b1;
    #1;
    chk1("ar_wr_drop", mem_write, 1'b0);
    chka("ar_addr", mem_addr, 28'h0);
    clr_in();
    #1;
    proc_reset = 1'b0;
    mem_ready  = 1'b1;
    #1;
    chk1("ar_late_d", d_mem_ready, 1'b0);
    chk1("ar_late_i", i_mem_ready, 1'b0);
    tick();
    mem_ready = 1'b0;
    chk1("ar_idle", mem_read | mem_write, 1'b0);
    v = '{1'b1, 28'h0000550, 1'b0, 1'b0, 28'h0, 128'h0, 2,
          128'h55, 1'b1, 1'b0, 28'h0000550, 128'h0, 1'b0};
    txn(v);
  endtask

  // transaction-level model: a free port takes the pending
  // client (alternating on contention), completion frees it,
  // and one release cycle passes before the next sample
  task automatic run_random();
    int owner;
    int gap;
    int mlast;
    int lat;
    int served;
    logic         p_ir, p_dr, p_dw, p_rdy;
    logic [27:0]  p_ia, p_da;
    logic [127:0] p_dwd;
    logic         e_rd, e_wr;
    logic [27:0]  e_addr;
    logic [127:0] e_wd;
    do_reset();
    owner = -1; gap = 0; mlast = 0; lat = 0;
    p_ir = 0; p_dr = 0; p_dw = 0; p_rdy = 0;
    p_ia = '0; p_da = '0; p_dwd = '0;
    e_rd = 0; e_wr = 0; e_addr = '0; e_wd = '0;
    for (int c = 0; c < 800; c++) begin
      served = -1;
      if (owner >= 0) begin
        if (p_rdy) begin
          served = owner;
          owner  = -1;
          gap    = 1;
        end
      end else if (gap > 0) begin
        gap = 0;
      end else if (p_ir || p_dr || p_dw) begin
        if (p_ir && (p_dr || p_dw)) begin
          owner = (mlast == 1) ? 0 : 1;
          mlast = owner;
        end else begin
          owner = p_ir ? 0 : 1;
        end
        if (owner == 0) begin
          e_rd = 1; e_wr = 0; e_addr = p_ia;
        end else begin
          e_wr = p_dw; e_rd = ~p_dw;
          e_addr = p_da; e_wd = p_dwd;
        end
        lat = int'($urandom_range(0, 3));
      end
      chk1("rnd_rd", mem_read, (owner >= 0) && e_rd);
      chk1("rnd_wr", mem_write, (owner >= 0) && e_wr);
      if (owner >= 0) begin
        chka("rnd_addr", mem_addr, e_addr);
        if (e_wr) chkd("rnd_wdata", mem_wdata, e_wd);
      end
      if (served == 0) begin
        i_mem_read = 1'b0;
      end else if (!i_mem_read && ($urandom % 3 == 0)) begin
        i_mem_read = 1'b1;
        i_mem_addr = 28'($urandom);
      end
      if (served == 1) begin
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
      end else if (!(d_mem_read || d_mem_write) &&
                   ($urandom % 3 == 0)) begin
        case ($urandom % 3)
          0: begin d_mem_read = 1'b1; d_mem_write = 1'b0; end
          1: begin d_mem_read = 1'b0; d_mem_write = 1'b1; end
          default: begin d_mem_read = 1'b1; d_mem_write = 1'b1; end
        endcase
        d_mem_addr  = 28'($urandom);
        d_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      if (owner >= 0) begin
        if (lat == 0) mem_ready = 1'b1;
        else begin
          mem_ready = 1'b0;
          lat--;
        end
      end else begin
        mem_ready = ($urandom % 8 == 0);
      end
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      chk1("rnd_iready", i_mem_ready, (owner == 0) && mem_ready);
      chk1("rnd_dready", d_mem_ready, (owner == 1) && mem_ready);
      if (owner >= 0 && mem_ready)
        chkd("rnd_rdata", owner == 1 ? d_mem_rdata : i_mem_rdata,
             mem_rdata);
      p_ir = i_mem_read; p_ia = i_mem_addr;
      p_dr = d_mem_read; p_dw = d_mem_write;
      p_da = d_mem_addr; p_dwd = d_mem_wdata;
      p_rdy = mem_ready;
      tick();
    end
    clr_in();
  endtask

  initial begin
    vt[0] = '{1'b1, 28'h0000040, 1'b0, 1'b0, 28'h0, 128'h0, 4,
              {16{8'hA5}}, 1'b1, 1'b0, 28'h0000040, 128'h0, 1'b0};
    vt[1] = '{1'b1, 28'h0000200, 1'b0, 1'b1, 28'h0000100, 128'h1234, 2,
              128'h1111, 1'b0, 1'b1, 28'h0000100, 128'h1234, 1'b1};
    vt[2] = '{1'b1, 28'h0000200, 1'b1, 1'b0, 28'h0000300, 128'h0, 1,
              128'h2222, 1'b1, 1'b0, 28'h0000200, 128'h0, 1'b0};
    vt[3] = '{1'b0, 28'h0, 1'b1, 1'b1, 28'h0000300, 128'hBEEF, 3,
              128'h3333, 1'b0, 1'b1, 28'h0000300, 128'hBEEF, 1'b1};
    vt[4] = '{1'b1, 28'h0000500, 1'b0, 1'b1, 28'h0000600, 128'h66, 2,
              128'h4444, 1'b0, 1'b1, 28'h0000600, 128'h66, 1'b1};
    vt[5] = '{1'b1, 28'h0000700, 1'b1, 1'b0, 28'h0000800, 128'h0, 1,
              128'h5555, 1'b1, 1'b0, 28'h0000700, 128'h0, 1'b0};
    vt[6] = '{1'b1, 28'h0000900, 1'b0, 1'b0, 28'h0, 128'h0, 2,
              128'h6666, 1'b1, 1'b0, 28'h0000900, 128'h0, 1'b0};
    vt[7] = '{1'b1, 28'h0000A00, 1'b1, 1'b0, 28'h0000B00, 128'h0, 2,
              128'h7777, 1'b1, 1'b0, 28'h0000B00, 128'h0, 1'b1};

    clr_in();
    proc_reset = 1'b0;
    tick();
    do_reset();
    for (int i = 0; i < 8; i++) txn(vt[i]);
    contention();
    stability();
    spurious();
    async_rst();
    run_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
